// File: rtl/request_capture4_pkg.sv
// Shared types and constants for the request capture front end.
// Holds the FSM encoding and the round-robin pick helper.
package request_capture4_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

    typedef logic [NUM_REQ-1:0] req_vec_t;
    typedef logic [SEL_W-1:0]   sel_t;

    typedef struct packed {
        logic found;
        sel_t sel;
    } rr_pick_t;

    // First set bit of pend searching ptr, ptr+1, ... with modulo-4 wrap.
    function automatic rr_pick_t rr_pick(req_vec_t pend, sel_t ptr);
        rr_pick_t r;
        sel_t     idx;
        r = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr + sel_t'(k);
            if (pend[idx]) begin
                r.found = 1'b1;
                r.sel   = idx;
            end
        end
        return r;
    endfunction

    function automatic req_vec_t onehot(sel_t s);
        return req_vec_t'(1) << s;
    endfunction

endpackage

// File: rtl/request_capture4_if.sv
// Request lines in, one-hot offer plus status out; master is the capture block.
// Consumer retires an offer by holding ready while en is high at a clock edge.
interface request_capture4_if;
    import request_capture4_pkg::*;

    req_vec_t req_in;
    logic     ready;
    req_vec_t x;
    logic     en;
    req_vec_t pending;
    req_vec_t overflow;

    modport master (
        input  req_in,
        input  ready,
        output x,
        output en,
        output pending,
        output overflow
    );

    modport slave (
        output req_in,
        output ready,
        input  x,
        input  en,
        input  pending,
        input  overflow
    );

endinterface

// File: rtl/request_capture4_debounce_line.sv
// One request line: 2-flop sync then a stability counter; rise flags the 0->1 flip.
// rise is combinational and true in the cycle before the edge where db becomes 1.
module debounce_line #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d  = raw;
        s2_d  = s1_q;
        db_d  = db_q;
        cnt_d = cnt_q;
        rise  = 1'b0;
        if (s2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            db_d  = s2_q;
            cnt_d = '0;
            rise  = s2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/request_capture4.sv
// Debounced request capture with round-robin one-hot offer; en rises DEBOUNCE_CYCLES+3 edges after input.
// Offer is held while ready=0; each retire is followed by one idle cycle.
module request_capture4
    import request_capture4_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic               clk,
    input  logic               rst,
    request_capture4_if.master bus
);

    req_vec_t   rise;

    logic [0:0] state_q, state_d;
    sel_t       ptr_q, ptr_d;
    sel_t       sel_q, sel_d;
    req_vec_t   x_q, x_d;
    logic       en_q, en_d;
    req_vec_t   pending_q, pending_d;
    req_vec_t   overflow_q, overflow_d;

    logic       retire;
    req_vec_t   retire_mask;
    rr_pick_t   pick;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_line
        debounce_line #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .raw  (bus.req_in[g]),
            .rise (rise[g])
        );
    end

    always_comb begin
        retire      = (state_q == ST_OFFER) && bus.ready;
        retire_mask = retire ? x_q : '0;

        // A rise on a line being retired at the same edge re-arms it without overflow.
        overflow_d  = rise & pending_q & ~retire_mask;
        pending_d   = (pending_q & ~retire_mask) | rise;

        pick    = rr_pick(pending_q, ptr_q);
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        x_d     = x_q;
        en_d    = en_q;

        case (state_q)
            ST_IDLE: begin
                if (pick.found) begin
                    sel_d   = pick.sel;
                    x_d     = onehot(pick.sel);
                    en_d    = 1'b1;
                    state_d = ST_OFFER;
                end else begin
                    x_d  = '0;
                    en_d = 1'b0;
                end
            end
            ST_OFFER: begin
                if (bus.ready) begin
                    ptr_d   = sel_q + sel_t'(1);
                    x_d     = '0;
                    en_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                x_d     = '0;
                en_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            sel_q      <= '0;
            x_q        <= '0;
            en_q       <= 1'b0;
            pending_q  <= '0;
            overflow_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            x_q        <= x_d;
            en_q       <= en_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.x        = x_q;
    assign bus.en       = en_q;
    assign bus.pending  = pending_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_request_capture4.sv
// Bench for request_capture4: vector table, directed corner sequences, then random traffic
// compared every cycle against a window-based behavioural model.
module tb_request_capture4;
    import request_capture4_pkg::*;

    localparam int DEB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    request_capture4_if bus();

    request_capture4 #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a line's level is accepted once the last DEB synchronised
    // samples all disagree with the current accepted level.
    bit [3:0] m_req_hist[$];
    bit [3:0] m_s2_hist[$];
    bit [3:0] m_db, m_pend, m_ovf, m_x;
    bit       m_en;
    int       m_ptr, m_sel;

    task automatic model_reset();
        m_req_hist = '{4'h0, 4'h0};
        m_s2_hist.delete();
        m_db  = '0;
        m_pend = '0;
        m_ovf = '0;
        m_x   = '0;
        m_en  = 1'b0;
        m_ptr = 0;
        m_sel = 0;
    endtask

    task automatic model_edge(bit r, bit [3:0] req, bit rdy);
        bit [3:0] s2pre, rise, rmask, old_pend;
        bit       all_diff, found;
        int       c;
        if (r) begin
            model_reset();
            return;
        end
        s2pre = m_req_hist[1];
        m_req_hist.push_front(req);
        void'(m_req_hist.pop_back());
        m_s2_hist.push_front(s2pre);
        if (m_s2_hist.size() > DEB) void'(m_s2_hist.pop_back());
        rise = '0;
        for (int i = 0; i < 4; i++) begin
            all_diff = (m_s2_hist.size() == DEB);
            for (int j = 0; j < m_s2_hist.size(); j++)
                if (m_s2_hist[j][i] == m_db[i]) all_diff = 1'b0;
            if (all_diff) begin
                m_db[i] = ~m_db[i];
                rise[i] = m_db[i];
            end
        end
        rmask    = (m_en && rdy) ? m_x : 4'h0;
        old_pend = m_pend;
        m_ovf    = rise & old_pend & ~rmask;
        m_pend   = (old_pend & ~rmask) | rise;
        if (m_en) begin
            if (rdy) begin
                m_ptr = (m_sel + 1) % 4;
                m_en  = 1'b0;
                m_x   = '0;
            end
        end else begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                c = (m_ptr + k) % 4;
                if (!found && old_pend[c]) begin
                    found = 1'b1;
                    m_sel = c;
                    m_x   = 4'(1 << c);
                    m_en  = 1'b1;
                end
            end
        end
    endtask

    task automatic step(bit r, bit [3:0] req, bit rdy);
        rst        = r;
        bus.req_in = req;
        bus.ready  = rdy;
        @(posedge clk);
        model_edge(r, req, rdy);
        #1;
        check("model", {19'h0, bus.x, bus.en, bus.pending, bus.overflow},
              {19'h0, m_x, m_en, m_pend, m_ovf});
    endtask

    typedef struct {
        bit       rst;
        bit [3:0] req;
        bit       rdy;
        bit [3:0] ex;
        bit       een;
        bit [3:0] ep;
        bit [3:0] eo;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int       k, ovf_cnt;
        bit       seen;
        bit       exp_en;
        bit [3:0] exp_offers[3];
        bit [3:0] cur;

        bus.req_in = '0;
        bus.ready  = 1'b0;
        model_reset();

        // Reset, then line 2 held with ready=1: offer on the 7th edge, retired on the 8th.
        tbl[0]  = '{1, 4'h0, 0, 4'h0, 0, 4'h0, 4'h0};
        tbl[1]  = '{1, 4'h0, 0, 4'h0, 0, 4'h0, 4'h0};
        for (int i = 2; i < 7; i++) tbl[i] = '{0, 4'h4, 1, 4'h0, 0, 4'h0, 4'h0};
        tbl[7]  = '{0, 4'h4, 1, 4'h0, 0, 4'h4, 4'h0};
        tbl[8]  = '{0, 4'h4, 1, 4'h4, 1, 4'h4, 4'h0};
        tbl[9]  = '{0, 4'h4, 1, 4'h0, 0, 4'h0, 4'h0};
        tbl[10] = '{0, 4'h4, 1, 4'h0, 0, 4'h0, 4'h0};
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].rdy);
            check($sformatf("tbl%0d_x", i),   32'(bus.x),        32'(tbl[i].ex));
            check($sformatf("tbl%0d_en", i),  32'(bus.en),       32'(tbl[i].een));
            check($sformatf("tbl%0d_pend", i), 32'(bus.pending), 32'(tbl[i].ep));
            check($sformatf("tbl%0d_ovf", i), 32'(bus.overflow), 32'(tbl[i].eo));
        end

        // Three-cycle glitch on line 0 must be rejected.
        step(1, 4'h0, 0);
        step(1, 4'h0, 0);
        for (int i = 0; i < 3; i++) step(0, 4'h1, 0);
        for (int i = 0; i < 12; i++) begin
            step(0, 4'h0, 0);
            check("glitch_pend", 32'(bus.pending), 32'h0);
            check("glitch_en",   32'(bus.en),      32'h0);
        end

        // Lines 0,1,3 together: offers 0001, 0010, 1000 with one idle cycle between.
        step(1, 4'h0, 1);
        step(1, 4'h0, 1);
        exp_offers = '{4'h1, 4'h2, 4'h8};
        k = 0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            step(0, 4'hB, 1);
            exp_en = (cyc == 7 || cyc == 9 || cyc == 11);
            check($sformatf("rr_en_c%0d", cyc), 32'(bus.en), 32'(exp_en));
            if (exp_en && k < 3) begin
                check($sformatf("rr_x%0d", k), 32'(bus.x), 32'(exp_offers[k]));
                k++;
            end
        end
        check("rr_pend_end", 32'(bus.pending), 32'h0);
        // Pointer must have wrapped to 0: lines 0 and 3 together offer line 0 first.
        for (int i = 0; i < 8; i++) step(0, 4'h0, 1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(0, 4'h9, 1);
            if (bus.en) begin
                seen = 1'b1;
                check("rr_ptr_wrap_x", 32'(bus.x), 32'h1);
            end
        end
        if (!seen) check("rr_ptr_wrap_timeout", 32'(seen), 32'h1);

        // Held offer while line 1 re-rises: single overflow pulse, pending stays set.
        step(1, 4'h0, 0);
        step(1, 4'h0, 0);
        for (int i = 0; i < 7; i++) step(0, 4'h2, 0);
        check("hold_en0", 32'(bus.en), 32'h1);
        check("hold_x0",  32'(bus.x),  32'h2);
        ovf_cnt = 0;
        for (int i = 0; i < 18; i++) begin
            step(0, (i < 8) ? 4'h0 : 4'h2, 0);
            if (bus.x !== 4'h2 || bus.en !== 1'b1 || bus.pending[1] !== 1'b1)
                check($sformatf("hold_stable_c%0d", i),
                      {23'h0, bus.x, bus.en, bus.pending}, {23'h0, 4'h2, 1'b1, 4'h2});
            if (bus.overflow == 4'h2) ovf_cnt++;
            else if (bus.overflow != 4'h0) check("hold_ovf_val", 32'(bus.overflow), 32'h2);
        end
        check("hold_ovf_count", 32'(ovf_cnt), 32'h1);
        step(0, 4'h2, 1);
        check("hold_retire_en",   32'(bus.en),      32'h0);
        check("hold_retire_pend", 32'(bus.pending), 32'h0);
        step(0, 4'h2, 1);
        check("hold_after_en", 32'(bus.en), 32'h0);

        // Reset in the middle of an offer drops it for good.
        step(1, 4'h0, 0);
        step(1, 4'h0, 0);
        for (int i = 0; i < 7; i++) step(0, 4'hA, 0);
        check("rst_pre_en",   32'(bus.en),      32'h1);
        check("rst_pre_x",    32'(bus.x),       32'h2);
        check("rst_pre_pend", 32'(bus.pending), 32'hA);
        step(1, 4'h0, 0);
        check("rst_mid_en",   32'(bus.en),      32'h0);
        check("rst_mid_x",    32'(bus.x),       32'h0);
        check("rst_mid_pend", 32'(bus.pending), 32'h0);
        for (int i = 0; i < 12; i++) begin
            step(0, 4'h0, 1);
            check("rst_no_reissue", 32'(bus.en), 32'h0);
        end

        // Random traffic: slowly toggling lines with glitches, random ready, rare resets.
        step(1, 4'h0, 0);
        cur = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 6) == 0) cur[b] = ~cur[b];
            step(($urandom_range(0, 599) == 0), cur, ($urandom_range(0, 2) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
